bcd_key_to_val: RTL and testbench



---
 rtl/keypad_pkg.sv | 65 ++++++
 rtl/dec_accum.sv | 27 ++
 rtl/bcd_key_to_val.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_key_to_val.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad-to-value assembly path.
//   - key code constants (digits 0-9 are their own value)
//   - format tags of the 12-bit tagged value word
//   - FSM state enum and a debug view struct
//   - assemble(): builds the tagged word from operand fields
// Optional feature macro used by the top: KEYPAD_ECHO_EN.
package keypad_pkg;

  localparam logic [3:0] KEY_MINUS = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  localparam logic [1:0] TAG_DUAL = 2'b00;
  localparam logic [1:0] TAG_WIDE = 2'b01;
  localparam logic [1:0] TAG_BIN  = 2'b10;
  localparam logic [1:0] TAG_ERR  = 2'b11;

  // Number of binary digits kept in tag 10; fixed by the word format.
  localparam int BIN_BITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPA  = 2'd1,
    ST_OPB  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Debug view of the entry FSM, convenient for binding checkers.
  typedef struct packed {
    state_t     state;
    logic [1:0] mode;
    logic       ovf;
  } fsm_dbg_t;

  // Build the tagged word. A zero magnitude always reports a positive
  // sign so that "-0" never reaches the display or the ALU.
  function automatic logic [11:0] assemble(
    input logic [1:0]          tag,
    input logic                err,
    input logic                sign_a,
    input logic [7:0]          mag_a,
    input logic                sign_b,
    input logic [3:0]          mag_b,
    input logic [BIN_BITS-1:0] bits
  );
    logic [11:0] w;
    logic        sa;
    logic        sb;
    sa = sign_a && (mag_a != 8'd0);
    sb = sign_b && (mag_b != 4'd0);
    w  = 12'd0;
    if (err || (tag == TAG_ERR)) begin
      w = {TAG_ERR, 10'd0};
    end else begin
      case (tag)
        TAG_DUAL: w = {TAG_DUAL, sa, mag_a[3:0], sb, mag_b};
        TAG_WIDE: w = {TAG_WIDE, 1'b0, sa, mag_a};
        TAG_BIN:  w = {TAG_BIN, 4'd0, bits};
        default:  w = {TAG_ERR, 10'd0};
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/dec_accum.sv
// dec_accum: combinational decimal accumulate step, acc*10 + digit, with
// a limit compare. Shared by both operands of the entry FSM.
// Ports:
//   acc      in  8  current magnitude
//   digit    in  4  decimal digit 0-9
//   limit    in  9  largest magnitude allowed
//   acc_next out 8  new magnitude (meaningful only when ovf is 0)
//   ovf      out 1  acc*10+digit exceeds limit
module dec_accum (
  input  logic [7:0] acc,
  input  logic [3:0] digit,
  input  logic [8:0] limit,
  output logic [7:0] acc_next,
  output logic       ovf
);

  // The product is formed 12 bits wide: 255*10+9 does not fit in 9 bits,
  // and a wrapped sum could slip under the limit and hide an overflow.
  logic [11:0] full;

  always_comb begin
    full     = ({4'd0, acc} * 12'd10) + {8'd0, digit};
    ovf      = (full > {3'd0, limit});
    acc_next = full[7:0];
  end

endmodule

// File: rtl/bcd_key_to_val.sv
// bcd_key_to_val: assembles a 12-bit tagged value word from a stream of
// keypad codes (inverse of the value-to-digit display path).
// Ports:
//   clk        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   mode       in   2   format tag, sampled on the first accepted key
//   key_code   in   4   0-9 digit, 10 minus, 11 clear, 12 enter, 13-15 reserved
//   key_valid  in   1   key_code valid
//   key_ready  out  1   key can be accepted (low only while a result waits)
//   val        out  12  {tag, payload}
//   val_valid  out  1   val holds a completed entry
//   val_ready  in   1   consumer accepts val
//   echo_val   out  12  live partial entry (only with KEYPAD_ECHO_EN)
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid never depends on ready, and val is held stable while val_valid.
// Optional feature macro: KEYPAD_ECHO_EN.
module bcd_key_to_val
  import keypad_pkg::*;
#(
  parameter int SMALL_MAX = 15,
  parameter int WIDE_MAX  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [11:0] val,
  output logic        val_valid,
`ifdef KEYPAD_ECHO_EN
  output logic [11:0] echo_val,
`endif
  input  logic        val_ready
);

  state_t                state;
  logic [1:0]            mode_q;
  logic                  sign_a;
  logic                  sign_b;
  logic [7:0]            acc_a;
  logic [3:0]            acc_b;
  logic [BIN_BITS-1:0]   bits;
  logic                  ovf;

  state_t                n_state;
  logic [1:0]            n_mode;
  logic                  n_sign_a;
  logic                  n_sign_b;
  logic [7:0]            n_acc_a;
  logic [3:0]            n_acc_b;
  logic [BIN_BITS-1:0]   n_bits;
  logic                  n_ovf;
  logic [11:0]           n_val;
  logic                  n_val_valid;

  logic                  key_fire;
  logic [1:0]            m;
  logic                  op_b;
  logic [7:0]            dec_acc;
  logic [8:0]            dec_limit;
  logic [7:0]            dec_next;
  logic                  dec_ovf;

  fsm_dbg_t              fsm_dbg;

  assign key_ready = (state != ST_DONE);
  assign key_fire  = key_valid && key_ready;
  assign fsm_dbg   = '{state: state, mode: mode_q, ovf: ovf};

  // In IDLE the incoming key already uses the live mode input, since that
  // key is both the one that latches the mode and the first one processed.
  assign m    = (state == ST_IDLE) ? mode : mode_q;
  assign op_b = (state == ST_OPB);

  assign dec_acc   = op_b ? {4'd0, acc_b} : acc_a;
  assign dec_limit = (m == TAG_DUAL) ? 9'(SMALL_MAX) : 9'(WIDE_MAX);

  dec_accum u_dec_accum (
    .acc      (dec_acc),
    .digit    (key_code),
    .limit    (dec_limit),
    .acc_next (dec_next),
    .ovf      (dec_ovf)
  );

  always_comb begin
    n_state     = state;
    n_mode      = mode_q;
    n_sign_a    = sign_a;
    n_sign_b    = sign_b;
    n_acc_a     = acc_a;
    n_acc_b     = acc_b;
    n_bits      = bits;
    n_ovf       = ovf;
    n_val       = val;
    n_val_valid = val_valid;

    if (state == ST_DONE) begin
      if (val_ready) begin
        n_state     = ST_IDLE;
        n_mode      = 2'd0;
        n_sign_a    = 1'b0;
        n_sign_b    = 1'b0;
        n_acc_a     = 8'd0;
        n_acc_b     = 4'd0;
        n_bits      = '0;
        n_ovf       = 1'b0;
        n_val       = 12'd0;
        n_val_valid = 1'b0;
      end
    end else if (key_fire) begin
      n_mode = m;
      if (key_code == KEY_CLEAR) begin
        n_state  = ST_IDLE;
        n_mode   = 2'd0;
        n_sign_a = 1'b0;
        n_sign_b = 1'b0;
        n_acc_a  = 8'd0;
        n_acc_b  = 4'd0;
        n_bits   = '0;
        n_ovf    = 1'b0;
      end else begin
        if (state == ST_IDLE) begin
          n_state = ST_OPA;
        end
        if (key_code <= 4'd9) begin
          case (m)
            TAG_DUAL, TAG_WIDE: begin
              // On overflow the accumulator keeps its last good value.
              if (dec_ovf) begin
                n_ovf = 1'b1;
              end else if (op_b) begin
                n_acc_b = dec_next[3:0];
              end else begin
                n_acc_a = dec_next;
              end
            end
            TAG_BIN: begin
              if (key_code > 4'd1) begin
                n_ovf = 1'b1;
              end else begin
                // Older bits fall off the top; only the last BIN_BITS stay.
                n_bits = {bits[BIN_BITS-2:0], key_code[0]};
              end
            end
            default: ;
          endcase
        end else if (key_code == KEY_MINUS) begin
          if ((m == TAG_DUAL) || (m == TAG_WIDE)) begin
            if (op_b) begin
              n_sign_b = ~sign_b;
            end else begin
              n_sign_a = ~sign_a;
            end
          end
        end else if (key_code == KEY_ENTER) begin
          if (!op_b && (m == TAG_DUAL)) begin
            n_state = ST_OPB;
          end else begin
            n_state     = ST_DONE;
            n_val_valid = 1'b1;
            n_val       = assemble(m, n_ovf, n_sign_a, n_acc_a,
                                   n_sign_b, n_acc_b, n_bits);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= 2'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      acc_a     <= 8'd0;
      acc_b     <= 4'd0;
      bits      <= '0;
      ovf       <= 1'b0;
      val       <= 12'd0;
      val_valid <= 1'b0;
    end else begin
      state     <= n_state;
      mode_q    <= n_mode;
      sign_a    <= n_sign_a;
      sign_b    <= n_sign_b;
      acc_a     <= n_acc_a;
      acc_b     <= n_acc_b;
      bits      <= n_bits;
      ovf       <= n_ovf;
      val       <= n_val;
      val_valid <= n_val_valid;
    end
  end

`ifdef KEYPAD_ECHO_EN
  // Echo mirrors the entry as it will look after this edge; IDLE shows 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_val <= 12'd0;
    end else if (n_state == ST_IDLE) begin
      echo_val <= 12'd0;
    end else if (key_fire) begin
      echo_val <= assemble(n_mode, n_ovf, n_sign_a, n_acc_a,
                           n_sign_b, n_acc_b, n_bits);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_key_to_val.sv
// tb_bcd_key_to_val: directed self-checking bench for bcd_key_to_val.
// Build with KEYPAD_ECHO_EN defined to also exercise echo_val.
module tb_bcd_key_to_val;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [11:0] val;
  logic        val_valid;
  logic        val_ready;
`ifdef KEYPAD_ECHO_EN
  logic [11:0] echo_val;
`endif

  int pass_cnt;
  int total_cnt;

  localparam logic [3:0] K_MINUS = 4'd10;
  localparam logic [3:0] K_CLEAR = 4'd11;
  localparam logic [3:0] K_ENTER = 4'd12;
  localparam logic [11:0] ERR_WORD = 12'hC00;

  bcd_key_to_val dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .val       (val),
    .val_valid (val_valid),
`ifdef KEYPAD_ECHO_EN
    .echo_val  (echo_val),
`endif
    .val_ready (val_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: all stimulus changes #1 after the rising edge.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic take_val();
    val_ready = 1'b1;
    @(posedge clk);
    #1;
    val_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (val !== 12'd0) $display("FAIL reset_val: got %h want %h", val, 12'd0);
    else pass_cnt++;
    total_cnt++;
    if (val_valid !== 1'b0) $display("FAIL reset_val_valid: got %b want 0", val_valid);
    else pass_cnt++;
    total_cnt++;
    if (key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b want 1", key_ready);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_dual();
    logic [11:0] exp;
    exp  = {2'b00, 1'b0, 4'd12, 1'b1, 4'd7};
    mode = 2'b00;
    press(4'd1);
    press(4'd2);
    press(K_ENTER);
    mode = 2'b11;  // ignored once the entry has started
    press(K_MINUS);
    press(4'd7);
    total_cnt++;
    if (val_valid !== 1'b0) $display("FAIL dual_early_valid: got %b want 0", val_valid);
    else pass_cnt++;
    press(K_ENTER);
    total_cnt++;
    if (val_valid !== 1'b1) $display("FAIL dual_valid: got %b want 1", val_valid);
    else pass_cnt++;
    total_cnt++;
    if (val !== exp) $display("FAIL dual_val: got %h want %h", val, exp);
    else pass_cnt++;
    total_cnt++;
    if (key_ready !== 1'b0) $display("FAIL dual_key_ready_done: got %b want 0", key_ready);
    else pass_cnt++;
    take_val();
    total_cnt++;
    if ((val_valid !== 1'b0) || (key_ready !== 1'b1))
      $display("FAIL dual_after_take: got valid=%b ready=%b want valid=0 ready=1",
               val_valid, key_ready);
    else pass_cnt++;
  endtask

  task automatic test_wide();
    logic [11:0] exp;
    exp  = {2'b01, 1'b0, 1'b1, 8'd255};
    mode = 2'b01;
    press(K_MINUS);
    press(4'd2);
    press(4'd5);
    press(4'd5);
    press(K_ENTER);
    total_cnt++;
    if ((val !== exp) || (val_valid !== 1'b1))
      $display("FAIL wide_255: got %h/%b want %h/1", val, val_valid, exp);
    else pass_cnt++;
    take_val();
    press(4'd2);
    press(4'd5);
    press(4'd6);
    press(K_ENTER);
    total_cnt++;
    if ((val !== ERR_WORD) || (val_valid !== 1'b1))
      $display("FAIL wide_256_ovf: got %h/%b want %h/1", val, val_valid, ERR_WORD);
    else pass_cnt++;
    take_val();
    press(4'd13);  // reserved, no effect
    press(4'd8);
    press(K_ENTER);
    exp = {2'b01, 1'b0, 1'b0, 8'd8};
    total_cnt++;
    if (val !== exp) $display("FAIL wide_reserved: got %h want %h", val, exp);
    else pass_cnt++;
    take_val();
  endtask

  task automatic test_bin();
    logic [11:0] exp;
    exp  = {2'b10, 4'b0000, 6'b011011};
    mode = 2'b10;
    press(4'd1); press(4'd0); press(4'd1); press(4'd1);
    press(K_MINUS);
    press(4'd0); press(4'd1); press(4'd1);
    press(K_ENTER);
    total_cnt++;
    if (val !== exp) $display("FAIL bin_seven_bits: got %h want %h", val, exp);
    else pass_cnt++;
    take_val();
    press(4'd1);
    press(4'd2);
    press(K_ENTER);
    total_cnt++;
    if (val !== ERR_WORD) $display("FAIL bin_bad_digit: got %h want %h", val, ERR_WORD);
    else pass_cnt++;
    take_val();
  endtask

  task automatic test_neg_zero();
    mode = 2'b00;
    press(K_MINUS);
    press(K_ENTER);
    press(K_ENTER);
    total_cnt++;
    if ((val !== 12'd0) || (val_valid !== 1'b1))
      $display("FAIL neg_zero: got %h/%b want 000/1", val, val_valid);
    else pass_cnt++;
    take_val();
  endtask

  task automatic test_dual_ovf_and_err_mode();
    mode = 2'b00;
    press(4'd1);
    press(4'd6);  // 16 > 15
    press(K_ENTER);
    press(K_ENTER);
    total_cnt++;
    if (val !== ERR_WORD) $display("FAIL dual_ovf: got %h want %h", val, ERR_WORD);
    else pass_cnt++;
    take_val();
    mode = 2'b11;
    press(4'd1);
    press(K_MINUS);
    press(K_ENTER);
    total_cnt++;
    if ((val !== ERR_WORD) || (val_valid !== 1'b1))
      $display("FAIL err_mode: got %h/%b want %h/1", val, val_valid, ERR_WORD);
    else pass_cnt++;
    take_val();
  endtask

  task automatic test_clear_and_rst();
    logic [11:0] exp;
    mode = 2'b00;
    press(4'd3);
    press(K_CLEAR);
    mode = 2'b01;
    press(4'd4);
    press(K_ENTER);
    exp = {2'b01, 1'b0, 1'b0, 8'd4};
    total_cnt++;
    if (val !== exp) $display("FAIL clear_then_wide: got %h want %h", val, exp);
    else pass_cnt++;
    take_val();
    mode = 2'b01;
    press(4'd5);
    pulse_rst();
    total_cnt++;
    if ((val !== 12'd0) || (val_valid !== 1'b0) || (key_ready !== 1'b1))
      $display("FAIL rst_mid: got val=%h valid=%b ready=%b want 000/0/1",
               val, val_valid, key_ready);
    else pass_cnt++;
    mode = 2'b10;
    press(4'd1);
    press(K_ENTER);
    exp = {2'b10, 4'b0000, 6'b000001};
    total_cnt++;
    if (val !== exp) $display("FAIL rst_fresh_entry: got %h want %h", val, exp);
    else pass_cnt++;
    take_val();
  endtask

  task automatic test_done_hold();
    logic [11:0] exp;
    exp  = {2'b00, 1'b0, 4'd9, 1'b0, 4'd0};
    mode = 2'b00;
    press(4'd9);
    press(K_ENTER);
    press(K_ENTER);
    key_code  = 4'd5;
    key_valid = 1'b1;
    val_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ((val !== exp) || (val_valid !== 1'b1) || (key_ready !== 1'b0))
        $display("FAIL done_hold_%0d: got val=%h valid=%b ready=%b want %h/1/0",
                 i, val, val_valid, key_ready, exp);
      else pass_cnt++;
    end
    key_valid = 1'b0;
    take_val();
    total_cnt++;
    if ((val_valid !== 1'b0) || (key_ready !== 1'b1))
      $display("FAIL done_release: got valid=%b ready=%b want 0/1", val_valid, key_ready);
    else pass_cnt++;
    mode = 2'b01;
    press(4'd3);
    press(K_ENTER);
    exp = {2'b01, 1'b0, 1'b0, 8'd3};
    total_cnt++;
    if (val !== exp) $display("FAIL done_no_stray_key: got %h want %h", val, exp);
    else pass_cnt++;
    take_val();
  endtask

`ifdef KEYPAD_ECHO_EN
  task automatic test_echo();
    logic [11:0] exp;
    mode = 2'b00;
    press(4'd1);
    exp = {2'b00, 1'b0, 4'd1, 1'b0, 4'd0};
    total_cnt++;
    if (echo_val !== exp) $display("FAIL echo_1: got %h want %h", echo_val, exp);
    else pass_cnt++;
    press(4'd2);
    press(K_ENTER);
    press(K_MINUS);
    exp = {2'b00, 1'b0, 4'd12, 1'b0, 4'd0};
    total_cnt++;
    if (echo_val !== exp) $display("FAIL echo_opb_empty: got %h want %h", echo_val, exp);
    else pass_cnt++;
    press(4'd7);
    exp = {2'b00, 1'b0, 4'd12, 1'b1, 4'd7};
    total_cnt++;
    if (echo_val !== exp) $display("FAIL echo_opb_7: got %h want %h", echo_val, exp);
    else pass_cnt++;
    press(K_ENTER);
    take_val();
    total_cnt++;
    if (echo_val !== 12'd0) $display("FAIL echo_idle: got %h want 000", echo_val);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    mode      = 2'b00;
    key_code  = 4'd0;
    key_valid = 1'b0;
    val_ready = 1'b0;
    test_reset();
    test_dual();
    test_wide();
    test_bin();
    test_neg_zero();
    test_dual_ovf_and_err_mode();
    test_clear_and_rst();
    test_done_hold();
`ifdef KEYPAD_ECHO_EN
    test_echo();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
